// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: merges memory wait,
// EX redirect and load-use hazard into register enables/flushes, with counters and DMEM timeout.
module pipeline_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DMEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_use_i,
  input  logic             redirect_EX_i,
  input  logic             dmem_req_MEM_i,
  input  logic             dmem_ready_i,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             MEM_WB_flush,
  output logic             dmem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WC_W = $clog2(DMEM_TIMEOUT + 1);

  // Control vector layout: {pc, IF_ID, ID_EX, EX_MEM, MEM_WB enables, IF_ID, ID_EX, MEM_WB flushes}
  localparam logic [7:0] CTL_STALL = 8'b00000_001;
  localparam logic [7:0] CTL_OFF   = 8'b00000_000;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    DMEM_WAIT = 2'b01,
    ERR       = 2'b10
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [WC_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              err_r;
  logic              memwait_s;
  logic              flush_evt_s;
  logic              stall_evt_s;
  logic [7:0]        ctl_s;

  // Redirect outranks load-use since the younger instruction is flushed anyway.
  function automatic logic [7:0] run_rules(input logic rd, input logic lu);
    logic [7:0] v;
    if (rd) begin
      v = 8'b11111_110;
    end else if (lu) begin
      v = 8'b00111_010;
    end else begin
      v = 8'b11111_000;
    end
    return v;
  endfunction

  assign memwait_s = dmem_req_MEM_i & ~dmem_ready_i;

  // Next-state and control decode.
  always_comb begin
    ctl_s          = CTL_OFF;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    flush_evt_s    = 1'b0;
    case (state_r)
      RUN: begin
        if (memwait_s) begin
          ctl_s          = CTL_STALL;
          state_nxt_s    = DMEM_WAIT;
          wait_cnt_nxt_s = WC_W'(1);
        end else begin
          ctl_s       = run_rules(redirect_EX_i, load_use_i);
          flush_evt_s = redirect_EX_i;
        end
      end
      DMEM_WAIT: begin
        if (memwait_s) begin
          ctl_s = CTL_STALL;
          if (wait_cnt_r == WC_W'(DMEM_TIMEOUT)) begin
            state_nxt_s = ERR;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + WC_W'(1);
          end
        end else begin
          // Ready, or request withdrawn: the access counts as complete.
          ctl_s       = run_rules(redirect_EX_i, load_use_i);
          flush_evt_s = redirect_EX_i;
          state_nxt_s = RUN;
        end
      end
      ERR: begin
        ctl_s = CTL_OFF;
      end
      default: begin
        ctl_s       = CTL_OFF;
        state_nxt_s = ERR;
      end
    endcase
  end

  assign stall_evt_s = ~ctl_s[7] & (state_r != ERR);

  // State, wait counter, sticky error and saturating event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= RUN;
      wait_cnt_r  <= '0;
      err_r       <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      if (state_nxt_s == ERR) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
      if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  // Reset forces enables low and flushes high without waiting for a clock.
  assign pc_en        = rst_ni & ctl_s[7];
  assign IF_ID_en     = rst_ni & ctl_s[6];
  assign ID_EX_en     = rst_ni & ctl_s[5];
  assign EX_MEM_en    = rst_ni & ctl_s[4];
  assign MEM_WB_en    = rst_ni & ctl_s[3];
  assign IF_ID_flush  = ~rst_ni | ctl_s[2];
  assign ID_EX_flush  = ~rst_ni | ctl_s[1];
  assign MEM_WB_flush = ~rst_ni | ctl_s[0];
  assign dmem_err_o   = err_r;
  assign stall_cnt_o  = stall_cnt_r;
  assign flush_cnt_o  = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (CNT_W=2, DMEM_TIMEOUT=4): driver queues
// hand-computed expectations, a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       load_use = 1'b0, redirect = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, dmem_err;
  logic [1:0] stall_cnt, flush_cnt;
  logic [7:0] ctl;

  int passed = 0;
  int total  = 0;

  localparam logic [7:0] RST = 8'b00000_111;
  localparam logic [7:0] RUN = 8'b11111_000;
  localparam logic [7:0] LU  = 8'b00111_010;
  localparam logic [7:0] RD  = 8'b11111_110;
  localparam logic [7:0] MW  = 8'b00000_001;
  localparam logic [7:0] OFF = 8'b00000_000;

  typedef struct {
    logic [7:0] ctl;
    logic       err;
    logic [1:0] sc;
    logic [1:0] fc;
    string      nm;
  } exp_t;

  exp_t q[$];

  pipeline_ctrl #(.CNT_W(2), .DMEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .load_use_i(load_use), .redirect_EX_i(redirect),
    .dmem_req_MEM_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_en(pc_en), .IF_ID_en(if_id_en), .ID_EX_en(id_ex_en), .EX_MEM_en(ex_mem_en),
    .MEM_WB_en(mem_wb_en), .IF_ID_flush(if_id_flush), .ID_EX_flush(id_ex_flush),
    .MEM_WB_flush(mem_wb_flush), .dmem_err_o(dmem_err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_wb_flush};

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic lu, input logic rd, input logic req,
                      input logic rdy, input logic [7:0] c, input logic err,
                      input logic [1:0] sc, input logic [1:0] fc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_ni = rst; load_use = lu; redirect = rd; dmem_req = req; dmem_ready = rdy;
    e.ctl = c; e.err = err; e.sc = sc; e.fc = fc; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a control vector; compare against the queue head.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (ctl === e.ctl) passed++;
      else $display("FAIL %s ctl: got %b want %b", e.nm, ctl, e.ctl);
      total++;
      if (dmem_err === e.err) passed++;
      else $display("FAIL %s err: got %b want %b", e.nm, dmem_err, e.err);
      total++;
      if (stall_cnt === e.sc) passed++;
      else $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, stall_cnt, e.sc);
      total++;
      if (flush_cnt === e.fc) passed++;
      else $display("FAIL %s flush_cnt: got %0d want %0d", e.nm, flush_cnt, e.fc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 1'b0, 2'd0, 2'd0, "reset");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, RST, 1'b0, 2'd0, 2'd0, "reset_inputs");

    // Load-use: exactly one bubble
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU,  1'b0, 2'd0, 2'd0, "lu_bubble");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b0, 2'd1, 2'd0, "lu_after");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b0, 2'd1, 2'd0, "lu_hold");

    // Redirect together with load-use
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 1'b0, 2'd0, 2'd0, "rst_b");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, RD,  1'b0, 2'd0, 2'd0, "rd_lu");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd1, "rd_after");

    // Memory wait for 3 cycles, then ready
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 1'b0, 2'd0, 2'd0, "rst_c");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd0, 2'd0, "mw1");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd1, 2'd0, "mw2");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd2, 2'd0, "mw3");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, RUN, 1'b0, 2'd3, 2'd0, "mw_ready");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b0, 2'd3, 2'd0, "mw_after");

    // Memory wait with redirect held: flush only on the ready cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 1'b0, 2'd0, 2'd0, "rst_d");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, MW,  1'b0, 2'd0, 2'd0, "mwrd1");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, MW,  1'b0, 2'd1, 2'd0, "mwrd2");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, RD,  1'b0, 2'd2, 2'd0, "mwrd_ready");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b0, 2'd2, 2'd1, "mwrd_after");

    // Request withdrawn without ready: treated as complete
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd2, 2'd1, "drop_wait");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU,  1'b0, 2'd3, 2'd1, "drop_lu");

    // Timeout: 1 RUN stall + 4 DMEM_WAIT cycles, then ERR; stall_cnt saturates at 3
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 1'b0, 2'd0, 2'd0, "rst_e");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd0, 2'd0, "to1");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd1, 2'd0, "to2");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd2, 2'd0, "to3");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd3, 2'd0, "to4");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd3, 2'd0, "to5");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, OFF, 1'b1, 2'd3, 2'd0, "err");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, OFF, 1'b1, 2'd3, 2'd0, "err_sticky");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 1'b0, 2'd0, 2'd0, "err_reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd0, "err_cleared");

    // Reset asserted mid-stall
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MW,  1'b0, 2'd0, 2'd0, "mid_wait");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RST, 1'b0, 2'd0, 2'd0, "mid_reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd0, "mid_release");

    // Five load-use stalls saturate the 2-bit stall counter
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST, 1'b0, 2'd0, 2'd0, "rst_f");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU,  1'b0, (i > 3) ? 2'd3 : 2'(i), 2'd0, "sat_lu");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b0, (i > 2) ? 2'd3 : 2'(i + 1), 2'd0, "sat_idle");
    end

    repeat (2) @(posedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
